bht_set_assoc: RTL and testbench

Parametrised successor to the pipeline's branch history table. It is an N-way set-associative branch target buffer with 2-bit saturating direction counters and per-set round-robin replacement. The IF stage queries it combinationally with the fetch address. The EXE stage updates it with the resolved branch outcome, gated by the pipeline-advance signal so updates freeze on stop/halt.

---
 rtl/bht_set_assoc.sv | 228 ++++++++++++++++++++++
 tb/tb_bht_set_assoc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_set_assoc.sv
// bht_set_assoc: N-way set-associative branch target buffer.
// Each entry holds a tag, a stored target and a 2-bit saturating direction counter.
// Each set has a round-robin victim pointer. IF queries combinationally; EXE updates
// on the clock edge when the pipeline advances.
// Optional feature macro: BHT_SET_ASSOC_PERF_EN adds saturating update and
// mispredict counters (perf_upd, perf_mispred).

// Per-way tag comparator, instantiated once per way for each lookup port
module bht_set_assoc_way_cmp #(
    parameter int TAG_W = 8
) (
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [TAG_W-1:0] key_i,
    output logic             hit_o
);
    assign hit_o = valid_i && (tag_i == key_i);
endmodule

module bht_set_assoc #(
    parameter int         ADDR_W   = 12,
    parameter int         ENTRIES  = 16,
    parameter int         WAYS     = 2,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              upd_en,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic [ADDR_W-1:0] qry_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target
`ifdef BHT_SET_ASSOC_PERF_EN
    ,
    output logic [31:0]       perf_upd,
    output logic [31:0]       perf_mispred
`endif
);
    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    // rr is logically zero-width for a direct-mapped table; keep one bit pinned at 0
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        ctr;
    } entry_t;

    entry_t [SETS-1:0][WAYS-1:0]   ent_q, ent_d;
    logic   [SETS-1:0][WAY_W-1:0]  rr_q, rr_d;

    logic [SET_W-1:0] q_idx, u_idx;
    logic [TAG_W-1:0] q_tag, u_tag;
    logic [WAYS-1:0]  q_hit_vec, u_hit_vec;
    logic             q_hit, u_hit;
    logic [1:0]       q_ctr, u_ctr;
    logic [ADDR_W-1:0] q_tgt;
    logic [WAY_W-1:0] u_way, victim;
    logic             found;

    // Byte-offset bits never participate in indexing or tagging
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{qry_pc[1:0], upd_pc[1:0]};

    // Address split into set index and tag for both lookup ports
    if (IDX_W > 0) begin : g_idx
        assign q_idx = qry_pc[IDX_W+1:2];
        assign u_idx = upd_pc[IDX_W+1:2];
    end else begin : g_noidx
        assign q_idx = '0;
        assign u_idx = '0;
    end
    assign q_tag = qry_pc[ADDR_W-1:IDX_W+2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Tag compare per way; tags within a set are unique, so at most one way hits
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        bht_set_assoc_way_cmp #(.TAG_W(TAG_W)) u_qcmp (
            .valid_i (ent_q[q_idx][w].valid),
            .tag_i   (ent_q[q_idx][w].tag),
            .key_i   (q_tag),
            .hit_o   (q_hit_vec[w])
        );
        bht_set_assoc_way_cmp #(.TAG_W(TAG_W)) u_ucmp (
            .valid_i (ent_q[u_idx][w].valid),
            .tag_i   (ent_q[u_idx][w].tag),
            .key_i   (u_tag),
            .hit_o   (u_hit_vec[w])
        );
    end

    // Query-side way select: pick counter and target of the hitting way
    always_comb begin
        q_hit = 1'b0;
        q_ctr = 2'b00;
        q_tgt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (q_hit_vec[w]) begin
                q_hit = 1'b1;
                q_ctr = ent_q[q_idx][w].ctr;
                q_tgt = ent_q[q_idx][w].target;
            end
        end
    end

    // Prediction reflects registered state only; no bypass from a same-cycle update
    assign pred_hit    = q_hit;
    assign pred_taken  = q_hit & q_ctr[1];
    assign pred_target = pred_taken ? q_tgt : qry_pc;

    // Update-side way select: encode the hitting way and fetch its counter
    always_comb begin
        u_hit = 1'b0;
        u_way = '0;
        u_ctr = 2'b00;
        for (int w = 0; w < WAYS; w++) begin
            if (u_hit_vec[w]) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
                u_ctr = ent_q[u_idx][w].ctr;
            end
        end
    end

    // Next-state: flush invalidates, else train on hit or allocate on taken miss
    always_comb begin
        ent_d  = ent_q;
        rr_d   = rr_q;
        victim = '0;
        found  = 1'b0;
        if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    ent_d[s][w].valid = 1'b0;
                end
            end
            rr_d = '0;
        end else if (upd_en && upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (u_ctr != 2'b11)
                        ent_d[u_idx][u_way].ctr = u_ctr + 2'd1;
                    ent_d[u_idx][u_way].target = upd_target;
                end else if (u_ctr != 2'b00) begin
                    ent_d[u_idx][u_way].ctr = u_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                // Fill the lowest empty way first; evict round-robin only when full
                for (int w = 0; w < WAYS; w++) begin
                    if (!found && !ent_q[u_idx][w].valid) begin
                        victim = WAY_W'(w);
                        found  = 1'b1;
                    end
                end
                if (!found) begin
                    victim = rr_q[u_idx];
                    if (WAYS > 1)
                        rr_d[u_idx] = rr_q[u_idx] + 1'b1;
                end
                ent_d[u_idx][victim].valid  = 1'b1;
                ent_d[u_idx][victim].tag    = u_tag;
                ent_d[u_idx][victim].target = upd_target;
                ent_d[u_idx][victim].ctr    = CTR_INIT;
            end
        end
    end

    // State registers; reset clears valids, parks counters at weakly not-taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    ent_q[s][w].valid  <= 1'b0;
                    ent_q[s][w].tag    <= '0;
                    ent_q[s][w].target <= '0;
                    ent_q[s][w].ctr    <= 2'b01;
                end
            end
            rr_q <= '0;
        end else begin
            ent_q <= ent_d;
            rr_q  <= rr_d;
        end
    end

`ifdef BHT_SET_ASSOC_PERF_EN
    logic [31:0] perf_upd_q, perf_upd_d, perf_mis_q, perf_mis_d;
    logic        u_pred_taken, u_mispred;

    // Compare the update-time prediction against the resolved outcome; saturating counts
    always_comb begin
        u_pred_taken = u_hit && u_ctr[1];
        u_mispred    = (u_pred_taken != upd_taken) ||
                       (u_pred_taken && (ent_q[u_idx][u_way].target != upd_target));
        perf_upd_d   = perf_upd_q;
        perf_mis_d   = perf_mis_q;
        if (!flush && upd_en && upd_valid) begin
            if (perf_upd_q != 32'hFFFF_FFFF)
                perf_upd_d = perf_upd_q + 32'd1;
            if (u_mispred && (perf_mis_q != 32'hFFFF_FFFF))
                perf_mis_d = perf_mis_q + 32'd1;
        end
    end

    // Perf counters survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_upd_q <= perf_upd_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_upd     = perf_upd_q;
    assign perf_mispred = perf_mis_q;
`endif
endmodule

// File: tb/tb_bht_set_assoc.sv
// Bench for bht_set_assoc (ADDR_W=12, ENTRIES=8, WAYS=2): directed scenarios plus
// random traffic against a line-level reference model of the branch target buffer.
module tb_bht_set_assoc;
    localparam int NSETS = 4;
    localparam int NWAYS = 2;

    logic        clk = 1'b0;
    logic        rst, flush, upd_en, upd_valid, upd_taken;
    logic [11:0] upd_pc, upd_target, qry_pc;
    logic        pred_hit, pred_taken;
    logic [11:0] pred_target;
`ifdef BHT_SET_ASSOC_PERF_EN
    logic [31:0] perf_upd, perf_mispred;
`endif

    always #5 clk = ~clk;

    bht_set_assoc #(.ADDR_W(12), .ENTRIES(8), .WAYS(2), .CTR_INIT(2'b10)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .upd_en      (upd_en),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .qry_pc      (qry_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
`ifdef BHT_SET_ASSOC_PERF_EN
        ,
        .perf_upd    (perf_upd),
        .perf_mispred(perf_mispred)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: each slot holds the full line tag (pc/16) or -1 when empty
    int m_tag [NSETS][NWAYS];
    int m_tgt [NSETS][NWAYS];
    int m_ctr [NSETS][NWAYS];
    int m_rr  [NSETS];
    int m_upd, m_mis;

    function automatic int m_find(input int pc);
        int s = (pc / 4) % NSETS;
        for (int w = 0; w < NWAYS; w++)
            if (m_tag[s][w] == pc / 16) return w;
        return -1;
    endfunction

    task automatic m_step(input bit r, input bit fl, input bit en, input bit v,
                          input int pc, input bit tk, input int tgt);
        int s, w, vic;
        bit pt;
        s = (pc / 4) % NSETS;
        if (!r) begin
            for (int i = 0; i < NSETS; i++) begin
                m_rr[i] = 0;
                for (int j = 0; j < NWAYS; j++) m_tag[i][j] = -1;
            end
            m_upd = 0;
            m_mis = 0;
        end else if (fl) begin
            for (int i = 0; i < NSETS; i++) begin
                m_rr[i] = 0;
                for (int j = 0; j < NWAYS; j++) m_tag[i][j] = -1;
            end
        end else if (en && v) begin
            w  = m_find(pc);
            pt = (w >= 0) && (m_ctr[s][w] >= 2);
            m_upd++;
            if ((pt != tk) || (pt && m_tgt[s][w] != tgt)) m_mis++;
            if (w >= 0) begin
                if (tk) begin
                    m_ctr[s][w] = (m_ctr[s][w] == 3) ? 3 : m_ctr[s][w] + 1;
                    m_tgt[s][w] = tgt;
                end else begin
                    m_ctr[s][w] = (m_ctr[s][w] == 0) ? 0 : m_ctr[s][w] - 1;
                end
            end else if (tk) begin
                vic = -1;
                for (int j = NWAYS - 1; j >= 0; j--)
                    if (m_tag[s][j] < 0) vic = j;
                if (vic < 0) begin
                    vic = m_rr[s];
                    m_rr[s] = (m_rr[s] + 1) % NWAYS;
                end
                m_tag[s][vic] = pc / 16;
                m_tgt[s][vic] = tgt;
                m_ctr[s][vic] = 2;
            end
        end
    endtask

    // One clock: drive, check the query against pre-edge model state, clock, advance model
    task automatic cyc(input bit r, input bit fl, input bit en, input bit v,
                       input int pc, input bit tk, input int tgt, input int q);
        int  w, s;
        bit  eh, et;
        int  etg;
        rst = r; flush = fl; upd_en = en; upd_valid = v;
        upd_pc = 12'(pc); upd_taken = tk; upd_target = 12'(tgt); qry_pc = 12'(q);
        #1;
        s   = (q / 4) % NSETS;
        w   = m_find(q);
        eh  = (w >= 0);
        et  = eh && (m_ctr[s][w] >= 2);
        etg = et ? m_tgt[s][w] : q;
        chk("pred_hit", 32'(pred_hit), 32'(eh));
        chk("pred_taken", 32'(pred_taken), 32'(et));
        chk("pred_target", 32'(pred_target), 32'(etg));
`ifdef BHT_SET_ASSOC_PERF_EN
        chk("perf_upd", perf_upd, 32'(m_upd));
        chk("perf_mispred", perf_mispred, 32'(m_mis));
`endif
        @(posedge clk);
        m_step(r, fl, en, v, pc, tk, tgt);
        #1;
    endtask

    task automatic upd(input int pc, input bit tk, input int tgt);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, pc, tk, tgt, pc);
    endtask

    // Query against constants stated for the scenario, no update in flight
    task automatic expect_q(input string tag, input int q, input bit h, input bit t, input int tg);
        rst = 1'b1; flush = 1'b0; upd_valid = 1'b0; qry_pc = 12'(q);
        #1;
        chk({tag, "_hit"}, 32'(pred_hit), 32'(h));
        chk({tag, "_taken"}, 32'(pred_taken), 32'(t));
        chk({tag, "_target"}, 32'(pred_target), 32'(tg));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        int pc, q, tg;
        bit r, fl, en, v, tk;
        rst = 1'b0; flush = 1'b0; upd_en = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0; qry_pc = 12'h010;
        repeat (2) @(posedge clk);
        m_step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        #1;

        // Reset state, and an update while reset is held is discarded
        expect_q("rst", 12'h010, 1'b0, 1'b0, 12'h010);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'h010, 1'b1, 12'h040, 12'h010);
        expect_q("rst_upd", 12'h010, 1'b0, 1'b0, 12'h010);
`ifdef BHT_SET_ASSOC_PERF_EN
        chk("perf_rst_upd", perf_upd, 32'd0);
        chk("perf_rst_mis", perf_mispred, 32'd0);
`endif

        // Allocation: same-cycle query sees miss, next cycle hits
        upd(12'h010, 1'b1, 12'h040);
        expect_q("alloc", 12'h010, 1'b1, 1'b1, 12'h040);

        // Counter walk down to 00 and back up to saturation
        upd(12'h010, 1'b0, 12'h040);
        upd(12'h010, 1'b0, 12'h040);
        expect_q("ctr00", 12'h010, 1'b1, 1'b0, 12'h010);
        upd(12'h010, 1'b1, 12'h044);
        expect_q("ctr01", 12'h010, 1'b1, 1'b0, 12'h010);
        upd(12'h010, 1'b1, 12'h048);
        expect_q("ctr10", 12'h010, 1'b1, 1'b1, 12'h048);
        upd(12'h010, 1'b1, 12'h04C);
        upd(12'h010, 1'b1, 12'h050);
        expect_q("ctr11", 12'h010, 1'b1, 1'b1, 12'h050);
        upd(12'h010, 1'b0, 12'h000);
        expect_q("ctr11_dec", 12'h010, 1'b1, 1'b1, 12'h050);
`ifdef BHT_SET_ASSOC_PERF_EN
        chk("perf_upd_8", perf_upd, 32'd8);
`endif

        // Replacement in set 0
        do_reset();
`ifdef BHT_SET_ASSOC_PERF_EN
        chk("perf_clr_upd", perf_upd, 32'd0);
        chk("perf_clr_mis", perf_mispred, 32'd0);
`endif
        upd(12'h000, 1'b1, 12'h100);
        upd(12'h010, 1'b1, 12'h110);
        upd(12'h020, 1'b1, 12'h120);
        expect_q("evict0_a", 12'h000, 1'b0, 1'b0, 12'h000);
        expect_q("evict0_b", 12'h010, 1'b1, 1'b1, 12'h110);
        expect_q("evict0_c", 12'h020, 1'b1, 1'b1, 12'h120);
        upd(12'h030, 1'b1, 12'h130);
        expect_q("evict1_a", 12'h010, 1'b0, 1'b0, 12'h010);
        expect_q("evict1_b", 12'h030, 1'b1, 1'b1, 12'h130);

        // Gating, miss-not-taken, flush dropping an update, rr reset by flush
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h044, 1'b1, 12'h200, 12'h044);
        expect_q("gated", 12'h044, 1'b0, 1'b0, 12'h044);
        upd(12'h054, 1'b0, 12'h200);
        expect_q("miss_nt", 12'h054, 1'b0, 1'b0, 12'h054);
        upd(12'h040, 1'b1, 12'h140);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 12'h048, 1'b1, 12'h300, 12'h048);
        expect_q("flush_a", 12'h030, 1'b0, 1'b0, 12'h030);
        expect_q("flush_b", 12'h040, 1'b0, 1'b0, 12'h040);
        expect_q("flush_upd", 12'h048, 1'b0, 1'b0, 12'h048);
        upd(12'h000, 1'b1, 12'h400);
        upd(12'h010, 1'b1, 12'h410);
        upd(12'h020, 1'b1, 12'h420);
        expect_q("post_flush_a", 12'h000, 1'b0, 1'b0, 12'h000);
        expect_q("post_flush_b", 12'h010, 1'b1, 1'b1, 12'h410);

        // Random traffic over a small address pool to force hits, evictions and saturation
        for (int i = 0; i < 3000; i++) begin
            pc = int'($urandom_range(0, 3)) * 16 + int'($urandom_range(0, 3)) * 4
                 + int'($urandom_range(0, 3));
            q  = ($urandom_range(0, 2) == 0) ? pc
                 : int'($urandom_range(0, 3)) * 16 + int'($urandom_range(0, 3)) * 4;
            tg = int'($urandom_range(0, 3)) * 256 + int'($urandom_range(0, 1)) * 4;
            r  = ($urandom_range(0, 299) != 0);
            fl = ($urandom_range(0, 59) == 0);
            en = ($urandom_range(0, 7) != 0);
            v  = ($urandom_range(0, 3) != 0);
            tk = ($urandom_range(0, 2) != 0);
            cyc(r, fl, en, v, pc, tk, tg, q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
